// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial BCD-to-binary converter.
// Provides the FSM state type, the digit width and the reverse double-dabble correction constants.
package bcd_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int         DIGIT_W     = 4;
    localparam logic [3:0] CORR_THRESH = 4'd8;
    localparam logic [3:0] CORR_OFFSET = 4'd3;

    // A nibble above 9 is not a decimal digit.
    function automatic logic digit_invalid(input logic [3:0] d);
        return (d > 4'd9);
    endfunction

endpackage

// File: rtl/bcd_sub3.sv
// Per-digit correction cell for reverse double-dabble: if the nibble is >= 8, subtract 3.
// Inverse of the add-3 cell used by the forward binary-to-BCD converter.
module bcd_sub3
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] din,
    output logic [DIGIT_W-1:0] dout
);

    // Conditional subtract on a freshly shifted BCD nibble
    always_comb begin
        dout = din;
        if (din >= CORR_THRESH) begin
            dout = din - CORR_OFFSET;
        end else begin
            dout = din;
        end
    end

endmodule

// File: rtl/bcd_to_bin_serial.sv
// Serial BCD-to-binary converter using reverse double-dabble, one bit per clock.
// Optional range/digit checking is enabled by defining BCD2BIN_RANGE_CHK_EN.
module bcd_to_bin_serial
    import bcd_pkg::*;
#(
    parameter int NDIG  = 3,
    parameter int BIN_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [DIGIT_W*NDIG-1:0] bcd,
    output logic                    busy,
    output logic                    done,
    output logic [BIN_W-1:0]        result,
    output logic                    err
);

    localparam int               BCD_W    = DIGIT_W * NDIG;
    localparam int               CNT_W    = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W);

    state_e             state_q, state_d;
    logic [BCD_W-1:0]   bcd_sr_q, bcd_sr_d;
    logic [BIN_W-1:0]   bin_sr_q, bin_sr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [BIN_W-1:0]   result_q, result_d;

    logic [BCD_W-1:0]   bcd_shift_s;
    logic [BCD_W-1:0]   bcd_corr_s;
    logic [BIN_W-1:0]   bin_shift_s;
    logic               accept_s;
    logic               finish_s;

    // The whole {bcd_sr, bin_sr} register moves right by one; the BCD LSB feeds the binary MSB.
    assign bcd_shift_s = {1'b0, bcd_sr_q[BCD_W-1:1]};
    assign bin_shift_s = {bcd_sr_q[0], bin_sr_q[BIN_W-1:1]};

    for (genvar g = 0; g < NDIG; g++) begin : g_sub3
        bcd_sub3 u_sub3 (
            .din  (bcd_shift_s[g*DIGIT_W +: DIGIT_W]),
            .dout (bcd_corr_s[g*DIGIT_W +: DIGIT_W])
        );
    end

    assign accept_s = (state_q == IDLE) && start;
    assign finish_s = (state_q == SHIFT) && (cnt_q == LAST_CNT);

    // Next-state and datapath update for the IDLE/SHIFT controller
    always_comb begin
        state_d  = state_q;
        bcd_sr_d = bcd_sr_q;
        bin_sr_d = bin_sr_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d  = SHIFT;
                    bcd_sr_d = bcd;
                    bin_sr_d = '0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                end else begin
                    busy_d   = 1'b0;
                end
            end
            SHIFT: begin
                // Counter reaching BIN_W means all shifts are done; this edge only publishes.
                if (finish_s) begin
                    state_d  = IDLE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    result_d = bin_sr_q;
                end else begin
                    bcd_sr_d = bcd_corr_s;
                    bin_sr_d = bin_shift_s;
                    cnt_d    = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            bcd_sr_q <= '0;
            bin_sr_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            bcd_sr_q <= bcd_sr_d;
            bin_sr_q <= bin_sr_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

`ifdef BCD2BIN_RANGE_CHK_EN
    logic dig_err_q, dig_err_d;
    logic err_q, err_d;

    // Digit validity is judged at capture; overflow shows as leftover BCD after the last shift.
    always_comb begin
        dig_err_d = dig_err_q;
        err_d     = err_q;
        if (accept_s) begin
            dig_err_d = 1'b0;
            for (int i = 0; i < NDIG; i++) begin
                dig_err_d = dig_err_d | digit_invalid(bcd[i*DIGIT_W +: DIGIT_W]);
            end
        end else if (finish_s) begin
            err_d = dig_err_q | (|bcd_sr_q);
        end else begin
            err_d = err_q;
        end
    end

    // Error flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            dig_err_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            dig_err_q <= dig_err_d;
            err_q     <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
